// File: rtl/register_file_pkg.sv
// ----------------------------------------------------------------------------
// regfile_types
// Shared types and constants for the architectural integer register file.
//   REG_COUNT  : number of architectural registers (x0..x31)
//   REG_ADDR_W : width of a register address
//   REG_ZERO   : address of the hard-wired zero register
//   reg_addr_t : register address type
// ----------------------------------------------------------------------------
package regfile_types;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = $clog2(REG_COUNT);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage : regfile_types

// File: rtl/register_file_decoder_5_32.sv
// ----------------------------------------------------------------------------
// decoder_5_32
// Address decoder producing one-hot per-register write enables.
//   i_addr   : register address
//   i_ena    : decode enable; all outputs low when deasserted
//   o_onehot : one-hot select, bit k high when i_ena and i_addr == k
// ----------------------------------------------------------------------------
module decoder_5_32
    import regfile_types::*;
(
    input  reg_addr_t              i_addr,
    input  logic                   i_ena,
    output logic [REG_COUNT-1:0]   o_onehot
);

    // NOTE: default assigned first so every path drives o_onehot; no latch.
    always_comb begin
        o_onehot = '0;
        if (i_ena) begin
            o_onehot[i_addr] = 1'b1;
        end
    end

endmodule : decoder_5_32

// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
// 32 x N architectural register file, two combinational read ports, one write
// port, x0 hard-wired to zero, optional same-cycle write-to-read bypass.
//   clk, rst_n          : clock, asynchronous active-low clear of x1..x31
//   rd_addr0 / rd_data0 : read port 0 (rs1, ALU operand a)
//   rd_addr1 / rd_data1 : read port 1 (rs2, ALU operand b)
//   wr_ena, wr_addr,
//   wr_data             : write port (rd), applied on rising clk
// Parameters:
//   N      : data width
//   BYPASS : 1 = reading the register being written returns wr_data
// ----------------------------------------------------------------------------
module register_file
    import regfile_types::*;
#(
    parameter int N      = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  reg_addr_t        rd_addr0,
    input  reg_addr_t        rd_addr1,
    output logic [N-1:0]     rd_data0,
    output logic [N-1:0]     rd_data1,
    input  logic             wr_ena,
    input  reg_addr_t        wr_addr,
    input  logic [N-1:0]     wr_data
);

    logic [REG_COUNT-1:0] w_dec;
    logic [REG_COUNT-1:0] w_we;
    logic [N-1:0]         w_rf [REG_COUNT];
    logic                 w_byp0;
    logic                 w_byp1;

    decoder_5_32 u_dec (
        .i_addr   (wr_addr),
        .i_ena    (wr_ena),
        .o_onehot (w_dec)
    );

    // x0 has no storage, so its enable is masked off here.
    assign w_we = w_dec & ~{{(REG_COUNT-1){1'b0}}, 1'b1};

    assign w_rf[0] = '0;

    for (genvar g = 1; g < REG_COUNT; g++) begin : g_reg
        logic [N-1:0] r_q;

        // NOTE: every storage flop has an async clear; this is an
        // architectural reset, not just a control-path one, so it is kept.
        // NOTE: non-blocking assignment for sequential state.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (w_we[g]) begin
                r_q <= wr_data;
            end
        end

        assign w_rf[g] = r_q;
    end

    // Bypass is qualified by rst_n so nothing leaks out during reset, and
    // never applies to x0.
    assign w_byp0 = BYPASS && rst_n && wr_ena &&
                    (wr_addr == rd_addr0) && (wr_addr != REG_ZERO);
    assign w_byp1 = BYPASS && rst_n && wr_ena &&
                    (wr_addr == rd_addr1) && (wr_addr != REG_ZERO);

    assign rd_data0 = w_byp0 ? wr_data : w_rf[rd_addr0];
    assign rd_data1 = w_byp1 ? wr_data : w_rf[rd_addr1];

endmodule : register_file

// File: tb/tb_register_file.sv
// ----------------------------------------------------------------------------
// tb_register_file
// Drives one BYPASS=1 and one BYPASS=0 instance with identical stimulus and
// compares both against an array-based reference model.
// ----------------------------------------------------------------------------
module tb_register_file;
    import regfile_types::*;

    localparam int N = 32;

    logic        clk;
    logic        rst_n;
    reg_addr_t   rd_addr0, rd_addr1, wr_addr;
    logic        wr_ena;
    logic [N-1:0] wr_data;
    logic [N-1:0] b_rd0, b_rd1, n_rd0, n_rd1;

    register_file #(.N(N), .BYPASS(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_data0(b_rd0), .rd_data1(b_rd1),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    register_file #(.N(N), .BYPASS(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_data0(n_rd0), .rd_data1(n_rd1),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] m_regs [32];

    typedef struct {
        logic         we;
        logic [4:0]   wa;
        logic [N-1:0] wd;
        logic [4:0]   ra0;
        logic [4:0]   ra1;
        logic [N-1:0] eb0;
        logic [N-1:0] eb1;
        logic [N-1:0] en0;
        logic [N-1:0] en1;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_rd(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 5'd0) return '0;
        if (byp && wr_ena && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    // Advance one clock; the model commits the write presented at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n && wr_ena && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
        #1;
    endtask

    task automatic check_reads(input string name);
        #1;
        check({name, "_b0"}, b_rd0, exp_rd(rd_addr0, 1'b1));
        check({name, "_b1"}, b_rd1, exp_rd(rd_addr1, 1'b1));
        check({name, "_n0"}, n_rd0, exp_rd(rd_addr0, 1'b0));
        check({name, "_n1"}, n_rd1, exp_rd(rd_addr1, 1'b0));
    endtask

    task automatic load_all();
        wr_ena = 1'b1;
        for (int i = 1; i < 32; i++) begin
            wr_addr = 5'(i);
            wr_data = 32'h1000_0000 + 32'(i);
            tick();
        end
        wr_ena = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5, 32'h11,        5'd5, 5'd5, 32'h11, 32'h11, 32'h1000_0005, 32'h1000_0005};
        vecs[1] = '{1'b1, 5'd5, 32'h22,        5'd5, 5'd5, 32'h22, 32'h22, 32'h11,        32'h11};
        vecs[2] = '{1'b0, 5'd5, 32'h33,        5'd5, 5'd0, 32'h22, 32'h0,  32'h22,        32'h0};
        vecs[3] = '{1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,         32'h0};
        vecs[4] = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd5, 32'h0,  32'h22, 32'h0,         32'h22};
        vecs[5] = '{1'b1, 5'd6, 32'h66,        5'd6, 5'd5, 32'h66, 32'h22, 32'h1000_0006, 32'h22};

        model_clear();

        // Reset with random write stimulus: everything reads zero.
        rst_n = 1'b0;
        rd_addr0 = '0; rd_addr1 = '0;
        wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 32; i++) begin
            wr_ena   = 1'($urandom);
            wr_addr  = 5'($urandom);
            wr_data  = $urandom;
            rd_addr0 = 5'(i);
            rd_addr1 = 5'(31 - i);
            tick();
            check_reads("reset_sweep");
        end
        @(negedge clk);
        wr_ena = 1'b0;
        rst_n  = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i);
            rd_addr1 = 5'($urandom);
            tick();
            check_reads("post_reset");
        end

        // Write/readback of every register, pairs (i, 31-i).
        load_all();
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i);
            rd_addr1 = 5'(31 - i);
            #1;
            check("readback0", b_rd0, (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i));
            check("readback1", n_rd1, (i == 31) ? 32'h0 : 32'h1000_0000 + 32'(31 - i));
        end

        // x0 protection: write presented, same cycle and next cycle read zero.
        wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF;
        rd_addr0 = 5'd0; rd_addr1 = 5'd0;
        #1;
        check("x0_same_b0", b_rd0, 32'h0);
        check("x0_same_b1", b_rd1, 32'h0);
        tick();
        wr_ena = 1'b0;
        #1;
        check("x0_next_b0", b_rd0, 32'h0);
        check("x0_next_n1", n_rd1, 32'h0);
        for (int i = 1; i < 32; i++) begin
            rd_addr0 = 5'(i);
            #1;
            check("x0_no_side", b_rd0, 32'h1000_0000 + 32'(i));
        end

        // Write enable gating on x7 over 10 cycles.
        wr_ena = 1'b0; wr_addr = 5'd7; wr_data = 32'hFFFF_FFFF;
        rd_addr0 = 5'd7; rd_addr1 = 5'd7;
        for (int i = 0; i < 10; i++) tick();
        check("gate_b", b_rd0, 32'h1000_0007);
        check("gate_n", n_rd1, 32'h1000_0007);

        // Bypass table: pre-edge reads checked, then the edge commits.
        for (int i = 0; i < 6; i++) begin
            wr_ena = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            rd_addr0 = vecs[i].ra0; rd_addr1 = vecs[i].ra1;
            #1;
            check($sformatf("vec%0d_b0", i), b_rd0, vecs[i].eb0);
            check($sformatf("vec%0d_b1", i), b_rd1, vecs[i].eb1);
            check($sformatf("vec%0d_n0", i), n_rd0, vecs[i].en0);
            check($sformatf("vec%0d_n1", i), n_rd1, vecs[i].en1);
            tick();
        end
        // Post-edge of the x5=0x22 write is covered by vec2; x6 here.
        wr_ena = 1'b0; rd_addr0 = 5'd6; rd_addr1 = 5'd6;
        #1;
        check("post_x6_b", b_rd0, 32'h66);
        check("post_x6_n", n_rd1, 32'h66);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            wr_ena   = 1'($urandom);
            wr_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wr_data  = $urandom;
            rd_addr0 = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
            rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
            check_reads("rand");
            tick();
        end

        // Reset mid-operation while a write to x9 is presented.
        load_all();
        wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 32'hABCD_0009;
        rd_addr0 = 5'd9; rd_addr1 = 5'd9;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("midrst_b0", b_rd0, 32'h0);
        check("midrst_b1", b_rd1, 32'h0);
        check("midrst_n0", n_rd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            #0.1;
            check("midrst_sweep", b_rd1, 32'h0);
        end
        tick();
        wr_ena = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_addr1 = 5'd9;
        tick();
        check("x9_after_rst_b", b_rd0, 32'h0);
        check("x9_after_rst_n", n_rd1, 32'h0);
        wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0999;
        tick();
        wr_ena = 1'b0;
        #1;
        check("x9_rewrite_b", b_rd0, 32'h0000_0999);
        check("x9_rewrite_n", n_rd1, 32'h0000_0999);
        check_reads("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_register_file
